seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller that shares one 4-bit-to-7-segment decode path across NDIG display digits.
- Holds a double-buffered digit register file loaded by a write/commit handshake.
- Cycles through the digits with a programmable on-time and an inter-digit blanking gap that prevents ghosting.
- Drives the one-hot digit enables and the registered segment bus that feed the board's common display pins.

---
 rtl/seg7_pkg.sv | 34 +++
 rtl/seg7_digit_decode.sv | 18 +
 rtl/seg7_scan_ctrl.sv | 152 +++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// +----------------------------------------------------------------------+
// | seg7_pkg : segment table, scan FSM state type, segment bit indices    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package seg7_pkg;

  localparam int SEG_W = 7;

  // Bit positions on the {g,f,e,d,c,b,a} segment bus
  typedef enum int {
    SEG_A = 0,
    SEG_B = 1,
    SEG_C = 2,
    SEG_D = 3,
    SEG_E = 4,
    SEG_F = 5,
    SEG_G = 6
  } seg_bit_e;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

`default_nettype wire

// File: rtl/seg7_digit_decode.sv
// +----------------------------------------------------------------------+
// | seg7_digit_decode : 4-bit hex value to active-high 7-segment pattern  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic [3:0]       i_nibble,
  output logic [SEG_W-1:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nibble];

endmodule

`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
// +----------------------------------------------------------------------+
// | seg7_scan_ctrl : multiplexed 7-seg scanner, double-buffered digits   |
// | Optional leading-zero blanking: define SEG7_SCAN_LZB_EN. Rev 1.0     |
// +----------------------------------------------------------------------+
`default_nettype none

module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NDIG      = 4,
  parameter int DIV       = 1000,
  parameter int BLANK_CYC = 16,
  localparam int AW       = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [3:0]      wr_data,
  input  logic            commit,
  output logic            commit_pend,
  output logic            frame_start,
  output logic [NDIG-1:0] dig_en,
  output logic [6:0]      led7s
);

  localparam int CMAX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [AW-1:0] IDX_LAST   = AW'(NDIG - 1);

  scan_state_e            state_q, state_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NDIG-1:0][3:0]   shadow_q, shadow_d;
  logic [NDIG-1:0][3:0]   active_q, active_d;
  logic                   commit_pend_q, commit_pend_d;
  logic                   frame_start_q, frame_start_d;
  logic [NDIG-1:0]        dig_en_q, dig_en_d;
  logic [SEG_W-1:0]       led7s_q, led7s_d;
  logic                   w_boundary;
  logic                   w_lzb;
  logic [3:0]             w_digit;
  logic [SEG_W-1:0]       w_seg;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q + 1'b1;
    w_boundary = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == DIV_LAST) begin
          state_d    = ST_BLANK;
          cnt_d      = '0;
          idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          w_boundary = (idx_d == '0);
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    shadow_d = shadow_q;
    if (wr_en && (32'(wr_addr) < NDIG)) begin
      shadow_d[wr_addr] = wr_data;
    end

    // Active copy takes the post-write shadow so a write in the boundary cycle is included
    active_d      = active_q;
    commit_pend_d = commit_pend_q;
    if (w_boundary && (commit_pend_q || commit)) begin
      active_d      = shadow_d;
      commit_pend_d = 1'b0;
    end else if (commit) begin
      commit_pend_d = 1'b1;
    end
  end

  assign w_digit = active_q[idx_d];

  seg7_digit_decode u_decode (
    .i_nibble (w_digit),
    .o_seg    (w_seg)
  );

`ifdef SEG7_SCAN_LZB_EN
  always_comb begin
    w_lzb = (idx_d != '0);
    for (int j = 0; j < NDIG; j++) begin
      if ((j >= int'(idx_d)) && (active_q[j] != 4'd0)) begin
        w_lzb = 1'b0;
      end
    end
  end
`else
  assign w_lzb = 1'b0;
`endif

  // Outputs are computed from the next state so they register on the same edge
  always_comb begin
    frame_start_d = w_boundary;
    dig_en_d      = '0;
    led7s_d       = '0;
    if (state_d == ST_DRIVE) begin
      dig_en_d = NDIG'(1) << idx_d;
      led7s_d  = w_lzb ? '0 : w_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BLANK;
      idx_q         <= '0;
      cnt_q         <= '0;
      shadow_q      <= '0;
      active_q      <= '0;
      commit_pend_q <= 1'b0;
      frame_start_q <= 1'b1;
      dig_en_q      <= '0;
      led7s_q       <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      commit_pend_q <= commit_pend_d;
      frame_start_q <= frame_start_d;
      dig_en_q      <= dig_en_d;
      led7s_q       <= led7s_d;
    end
  end

  assign commit_pend = commit_pend_q;
  assign frame_start = frame_start_q;
  assign dig_en      = dig_en_q;
  assign led7s       = led7s_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_seg7_scan_ctrl : bench for seg7_scan_ctrl (NDIG=4 DIV=4 BLANK=2)   |
// | Honours SEG7_SCAN_LZB_EN. Rev 1.0                                    |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_seg7_scan_ctrl;

  localparam int NDIG      = 4;
  localparam int DIV       = 4;
  localparam int BLANK_CYC = 2;
  localparam int SLOT      = BLANK_CYC + DIV;
  localparam int FRAME     = NDIG * SLOT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = 2'd0;
  logic [3:0] wr_data = 4'd0;
  logic       commit = 1'b0;
  logic       commit_pend;
  logic       frame_start;
  logic [3:0] dig_en;
  logic [6:0] led7s;

  int nvec = 0;
  int nmis = 0;

  // Model: cycle number since reset release plus shadow/active/pending contents
  int t = -1;
  int m_shadow [NDIG];
  int m_active [NDIG];
  bit m_pend;
  bit m_bnd;

  logic [6:0] seg_ref [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  seg7_scan_ctrl #(
    .NDIG      (NDIG),
    .DIV       (DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .commit      (commit),
    .commit_pend (commit_pend),
    .frame_start (frame_start),
    .dig_en      (dig_en),
    .led7s       (led7s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      t = 0;
      for (int i = 0; i < NDIG; i++) begin
        m_shadow[i] = 0;
        m_active[i] = 0;
      end
      m_pend = 1'b0;
    end else if (t >= 0) begin
      m_bnd = ((t + 1) % FRAME == 0);
      if (wr_en && (int'(wr_addr) < NDIG)) m_shadow[wr_addr] = int'(wr_data);
      if (m_bnd && (m_pend || commit)) begin
        m_active = m_shadow;
        m_pend   = 1'b0;
      end else if (commit) begin
        m_pend = 1'b1;
      end
      t = t + 1;
    end
  end

  function automatic logic [3:0] exp_dig(input int tt);
    int p = tt % FRAME;
    if ((p % SLOT) < BLANK_CYC) return 4'd0;
    return 4'(1 << (p / SLOT));
  endfunction

  function automatic logic [6:0] exp_led(input int tt);
    int p = tt % FRAME;
    int i = p / SLOT;
    if ((p % SLOT) < BLANK_CYC) return 7'd0;
`ifdef SEG7_SCAN_LZB_EN
    if (i > 0) begin
      bit z = 1'b1;
      for (int j = i; j < NDIG; j++) if (m_active[j] != 0) z = 1'b0;
      if (z) return 7'd0;
    end
`endif
    return seg_ref[m_active[i]];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s at t=%0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (t >= 0) begin
      chk("frame_start", 32'(frame_start), 32'(t % FRAME == 0));
      chk("dig_en", 32'(dig_en), 32'(exp_dig(t)));
      chk("led7s", 32'(led7s), 32'(exp_led(t)));
      chk("commit_pend", 32'(commit_pend), 32'(m_pend));
    end
  end

  task automatic wait_pos(input int p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((t % FRAME) != p) && (n < 4 * FRAME));
    if ((t % FRAME) != p) begin
      nvec++;
      nmis++;
      $display("FAIL wait_pos: got position %0d expected %0d", t % FRAME, p);
    end
  endtask

  task automatic wr(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = 2'(a);
    wr_data = 4'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset release
    chk("rel_fs0", 32'(frame_start), 32'd1);
    chk("rel_den0", 32'(dig_en), 32'd0);
    chk("rel_led0", 32'(led7s), 32'd0);
    @(negedge clk);
    chk("rel_fs1", 32'(frame_start), 32'd0);
    chk("rel_den1", 32'(dig_en), 32'd0);
    @(negedge clk);
    chk("rel_den2", 32'(dig_en), 32'b0001);
    chk("rel_led2", 32'(led7s), 32'b0111111);
    wait_pos(0);
    chk("rel_fs24", 32'(frame_start), 32'd1);

    // Scan order after committing 3,2,1,0
    wr(3, 3);
    wr(2, 2);
    wr(1, 1);
    wr(0, 0);
    pulse_commit();
    chk("scan_pend", 32'(commit_pend), 32'd1);
    wait_pos(2);
    chk("scan_d0", {dig_en, 1'b0, led7s}, {4'b0001, 1'b0, 7'b0111111});
    wait_pos(8);
    chk("scan_d1", {dig_en, 1'b0, led7s}, {4'b0010, 1'b0, 7'b0000110});
    wait_pos(14);
    chk("scan_d2", {dig_en, 1'b0, led7s}, {4'b0100, 1'b0, 7'b1011011});
    wait_pos(20);
    chk("scan_d3", {dig_en, 1'b0, led7s}, {4'b1000, 1'b0, 7'b1001111});
    chk("scan_nopend", 32'(commit_pend), 32'd0);

    // Write without commit leaves the display alone
    wait_pos(3);
    wr(1, 15);
    repeat (3 * FRAME) @(negedge clk);
    wait_pos(8);
    chk("nocommit_d1", 32'(led7s), 32'b0000110);

    // Mid-frame commit
    wait_pos(10);
    pulse_commit();
    chk("mid_pend_a", 32'(commit_pend), 32'd1);
    wait_pos(23);
    chk("mid_pend_b", 32'(commit_pend), 32'd1);
    wait_pos(0);
    chk("mid_pend_clr", 32'(commit_pend), 32'd0);
    wait_pos(8);
    chk("mid_d1", 32'(led7s), 32'b1110001);

    // Write and commit together in the boundary cycle
    wait_pos(23);
    wr_en   = 1'b1;
    wr_addr = 2'd0;
    wr_data = 4'd8;
    commit  = 1'b1;
    @(negedge clk);
    wr_en  = 1'b0;
    commit = 1'b0;
    chk("bnd_fs", 32'(frame_start), 32'd1);
    chk("bnd_pend", 32'(commit_pend), 32'd0);
    wait_pos(2);
    chk("bnd_d0", 32'(led7s), 32'b1111111);

    // Reset during DRIVE of idx 2 drops a pending commit
    wait_pos(3);
    wr(2, 5);
    pulse_commit();
    wait_pos(14);
    chk("rst_pre_den", 32'(dig_en), 32'b0100);
    chk("rst_pre_pend", 32'(commit_pend), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_den", 32'(dig_en), 32'd0);
    chk("rst_led", 32'(led7s), 32'd0);
    chk("rst_pend", 32'(commit_pend), 32'd0);
    wait_pos(2);
    chk("rst_d0", 32'(led7s), 32'b0111111);
    wait_pos(14);
`ifdef SEG7_SCAN_LZB_EN
    chk("rst_d2", 32'(led7s), 32'd0);
`else
    chk("rst_d2", 32'(led7s), 32'b0111111);
`endif

    // Active {0,0,0,5}: leading-zero blanking when enabled
    wr(0, 5);
    pulse_commit();
    wait_pos(2);
    chk("lz_d0", 32'(led7s), 32'b1101101);
    wait_pos(8);
    chk("lz_den1", 32'(dig_en), 32'b0010);
`ifdef SEG7_SCAN_LZB_EN
    chk("lz_d1", 32'(led7s), 32'd0);
    wait_pos(20);
    chk("lz_d3", 32'(led7s), 32'd0);
`else
    chk("lz_d1", 32'(led7s), 32'b0111111);
    wait_pos(20);
    chk("lz_d3", 32'(led7s), 32'b0111111);
`endif

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

`default_nettype wire
